// File: rtl/rtc_pkg.sv
// Shared field widths, range limits and the 12-hour display mapping for the
// time-of-day counter.
package rtc_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int OUT_W  = 6;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Midnight and noon both display as 12; afternoon hours fold down by 12.
    function automatic logic [OUT_W-1:0] to_12h(input logic [HOUR_W-1:0] h24);
        logic [HOUR_W-1:0] h12;
        if (h24 == '0)
            h12 = 5'd12;
        else if (h24 > 5'd12)
            h12 = h24 - 5'd12;
        else
            h12 = h24;
        return OUT_W'(h12);
    endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry flags the wrap step so
// counters can be chained into a cascade.
module rtc_mod_counter #(
    parameter int          W   = 6,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] r_value;

    assign carry = en && (r_value == MAX);
    assign value = r_value;

    always_ff @(posedge clk) begin
        if (rst)
            r_value <= '0;
        else if (load)
            r_value <= load_val;
        else if (en)
            r_value <= (r_value == MAX) ? '0 : r_value + W'(1);
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// HH:MM:SS time-of-day counter with prescaler, run/halt, synchronous load,
// 12/24-hour display and a sticky hours:minutes alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 40_000_000,
    parameter int TICK_W   = $clog2(TICK_DIV)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              run_i,
    input  logic              mode12_i,
    input  logic              load_i,
    input  logic [HOUR_W-1:0] set_hours_i,
    input  logic [MIN_W-1:0]  set_minutes_i,
    input  logic [SEC_W-1:0]  set_seconds_i,
    input  logic              alarm_en_i,
    input  logic [HOUR_W-1:0] alarm_hours_i,
    input  logic [MIN_W-1:0]  alarm_minutes_i,
    input  logic              alarm_ack_i,
    output logic [OUT_W-1:0]  hours_o,
    output logic [OUT_W-1:0]  minutes_o,
    output logic [OUT_W-1:0]  seconds_o,
    output logic              pm_o,
    output logic              tick_o,
    output logic              alarm_o
);

    logic [TICK_W-1:0] r_pre;
    logic              r_tick;
    logic              r_alarm;

    logic              w_tick;
    logic              w_tick_eff;
    logic [SEC_W-1:0]  w_sec;
    logic [MIN_W-1:0]  w_min;
    logic [HOUR_W-1:0] w_hour;
    logic              w_sec_carry;
    logic              w_min_carry;
    logic              w_hour_carry;
    logic [SEC_W-1:0]  w_ld_sec;
    logic [MIN_W-1:0]  w_ld_min;
    logic [HOUR_W-1:0] w_ld_hour;
    logic [MIN_W-1:0]  w_min_nxt;
    logic [HOUR_W-1:0] w_hour_nxt;
    logic              w_alarm_set;

    assign w_tick     = run_i && (r_pre == TICK_W'(TICK_DIV - 1));
    // A load in the same cycle swallows the tick entirely.
    assign w_tick_eff = w_tick && !load_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            r_pre <= '0;
        else if (load_i || w_tick)
            r_pre <= '0;
        else if (run_i)
            r_pre <= r_pre + TICK_W'(1);
    end

    assign w_ld_sec  = (set_seconds_i > SEC_MAX)  ? '0 : set_seconds_i;
    assign w_ld_min  = (set_minutes_i > MIN_MAX)  ? '0 : set_minutes_i;
    assign w_ld_hour = (set_hours_i   > HOUR_MAX) ? '0 : set_hours_i;

    rtc_mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .en       (w_tick_eff),
        .load     (load_i),
        .load_val (w_ld_sec),
        .value    (w_sec),
        .carry    (w_sec_carry)
    );

    rtc_mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .en       (w_sec_carry),
        .load     (load_i),
        .load_val (w_ld_min),
        .value    (w_min),
        .carry    (w_min_carry)
    );

    rtc_mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .en       (w_min_carry),
        .load     (load_i),
        .load_val (w_ld_hour),
        .value    (w_hour),
        .carry    (w_hour_carry)
    );

    // Alarm compares against the time the current tick is about to produce;
    // only a seconds wrap can land on hh:mm:00, so it gates the match.
    assign w_min_nxt  = w_min_carry ? '0 : w_min + MIN_W'(1);
    assign w_hour_nxt = w_hour_carry ? '0 :
                        (w_min_carry ? w_hour + HOUR_W'(1) : w_hour);
    assign w_alarm_set = alarm_en_i && w_sec_carry &&
                         (w_min_nxt == alarm_minutes_i) &&
                         (w_hour_nxt == alarm_hours_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tick  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_tick <= w_tick_eff;
            if (w_alarm_set)
                r_alarm <= 1'b1;
            else if (alarm_ack_i)
                r_alarm <= 1'b0;
        end
    end

    assign hours_o   = mode12_i ? to_12h(w_hour) : OUT_W'(w_hour);
    assign minutes_o = OUT_W'(w_min);
    assign seconds_o = OUT_W'(w_sec);
    assign pm_o      = (w_hour >= 5'd12);
    assign tick_o    = r_tick;
    assign alarm_o   = r_alarm;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a seconds-of-day reference model.
module tb_rtc_timekeeper;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mode12 = 1'b0;
    logic       load = 1'b0;
    logic [4:0] set_h = '0;
    logic [5:0] set_m = '0;
    logic [5:0] set_s = '0;
    logic       al_en = 1'b0;
    logic [4:0] al_h = '0;
    logic [5:0] al_m = '0;
    logic       ack = 1'b0;
    logic [5:0] hours_o, minutes_o, seconds_o;
    logic       pm_o, tick_o, alarm_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    // Reference state: time as seconds since midnight, prescaler count, flags.
    int m_t = 0;
    int m_pre = 0;
    bit m_tick = 0;
    bit m_alarm = 0;

    rtc_timekeeper #(.TICK_DIV(DIV)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .run_i           (run),
        .mode12_i        (mode12),
        .load_i          (load),
        .set_hours_i     (set_h),
        .set_minutes_i   (set_m),
        .set_seconds_i   (set_s),
        .alarm_en_i      (al_en),
        .alarm_hours_i   (al_h),
        .alarm_minutes_i (al_m),
        .alarm_ack_i     (ack),
        .hours_o         (hours_o),
        .minutes_o       (minutes_o),
        .seconds_o       (seconds_o),
        .pm_o            (pm_o),
        .tick_o          (tick_o),
        .alarm_o         (alarm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp_hour(input int h, input bit m12);
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    always @(posedge clk) begin
        int  t, p, hs, ms, ss;
        bit  tk, al;
        t = m_t; p = m_pre; tk = 0; al = m_alarm;
        if (rst) begin
            t = 0; p = 0; al = 0;
        end else if (load) begin
            hs = (set_h > 23) ? 0 : int'(set_h);
            ms = (set_m > 59) ? 0 : int'(set_m);
            ss = (set_s > 59) ? 0 : int'(set_s);
            t = hs * 3600 + ms * 60 + ss;
            p = 0;
            if (ack) al = 0;
        end else if (run && p == DIV - 1) begin
            t = (t + 1) % 86400;
            p = 0;
            tk = 1;
            if (al_en && al_h <= 23 && al_m <= 59 && t % 60 == 0 &&
                t / 60 == int'(al_h) * 60 + int'(al_m))
                al = 1;
            else if (ack)
                al = 0;
        end else begin
            if (run) p = p + 1;
            if (ack) al = 0;
        end
        m_t <= t;
        m_pre <= p;
        m_tick <= tk;
        m_alarm <= al;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hours", hours_o, disp_hour(m_t / 3600, mode12));
            chk("minutes", minutes_o, (m_t / 60) % 60);
            chk("seconds", seconds_o, m_t % 60);
            chk("pm", pm_o, (m_t / 3600) >= 12);
            chk("tick", tick_o, m_tick);
            chk("alarm", alarm_o, m_alarm);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        set_h = 5'(h); set_m = 6'(m); set_s = 6'(s);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    int n_ticks;
    int exp12[4] = '{12, 12, 1, 11};
    int exppm[4] = '{0, 1, 1, 1};
    int hl[4] = '{0, 12, 13, 23};

    initial begin
        cyc(2);
        chk_en = 1;
        chk("rst_hours24", hours_o, 0);
        chk("rst_seconds", seconds_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_alarm", alarm_o, 0);
        mode12 = 1'b1;
        #1;
        chk("rst_hours12", hours_o, 12);
        chk("rst_pm", pm_o, 0);
        mode12 = 1'b0;

        // Free run from reset.
        rst = 1'b0;
        run = 1'b1;
        n_ticks = 0;
        for (int i = 0; i < 8 * DIV; i++) begin
            cyc(1);
            if (tick_o) n_ticks++;
        end
        chk("freerun_sec", seconds_o, 8);
        chk("freerun_ticks", n_ticks, 8);
        chk("model_sec", m_t, 8);

        // Midnight rollover.
        do_load(23, 59, 58);
        cyc(DIV);
        chk("roll_pre_sec", seconds_o, 59);
        chk("roll_pre_pm", pm_o, 1);
        cyc(DIV);
        chk("roll_hours", hours_o, 0);
        chk("roll_minutes", minutes_o, 0);
        chk("roll_seconds", seconds_o, 0);
        chk("roll_pm", pm_o, 0);
        chk("roll_tick", tick_o, 1);

        // 12-hour display mapping.
        run = 1'b0;
        mode12 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_load(hl[i], 0, 0);
            chk("m12_hours", hours_o, exp12[i]);
            chk("m12_pm", pm_o, exppm[i]);
        end
        mode12 = 1'b0;

        // Alarm set, set-beats-ack, ack alone.
        al_en = 1'b1; al_h = 5'd7; al_m = 6'd30;
        run = 1'b1;
        do_load(7, 29, 58);
        cyc(DIV);
        chk("alarm_early", alarm_o, 0);
        cyc(DIV);
        chk("alarm_set", alarm_o, 1);
        chk("alarm_tick", tick_o, 1);
        do_load(7, 29, 59);
        chk("alarm_load_keeps", alarm_o, 1);
        cyc(DIV - 1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("alarm_set_wins", alarm_o, 1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("alarm_ack", alarm_o, 0);
        do_load(7, 30, 0);
        chk("alarm_load_nofire", alarm_o, 0);
        al_en = 1'b0;

        // Halt keeps the partial second.
        do_load(0, 0, 0);
        cyc(2);
        run = 1'b0;
        cyc(10);
        run = 1'b1;
        cyc(1);
        chk("halt_notick", tick_o, 0);
        cyc(1);
        chk("halt_tick", tick_o, 1);
        chk("halt_sec", seconds_o, 1);

        // Load coincident with a tick.
        do_load(0, 0, 0);
        cyc(DIV - 1);
        do_load(10, 20, 30);
        chk("ldtick_sec", seconds_o, 30);
        chk("ldtick_tick", tick_o, 0);

        // Out-of-range minutes load as zero.
        do_load(5, 60, 5);
        chk("oor_min", minutes_o, 0);
        chk("oor_hours", hours_o, 5);
        chk("oor_sec", seconds_o, 5);

        // Reset mid-count.
        cyc(6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_mid_hours", hours_o, 0);
        chk("rst_mid_minutes", minutes_o, 0);
        chk("rst_mid_seconds", seconds_o, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int a_h, a_m;
            run    = ($urandom_range(0, 9) != 0);
            mode12 = $urandom_range(0, 1);
            ack    = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 299) == 0);
            al_en  = ($urandom_range(0, 3) != 0);
            load   = ($urandom_range(0, 39) == 0);
            if (load) begin
                a_h = $urandom_range(0, 25);
                a_m = $urandom_range(0, 61);
                al_h = 5'(a_h);
                al_m = 6'(a_m);
                set_h = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(a_h);
                set_m = (a_m == 0) ? 6'd59 : 6'(a_m - 1);
                set_s = 6'($urandom_range(50, 63));
            end
            cyc(1);
        end
        load = 1'b0; ack = 1'b0; rst = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised time-of-day counter for the user project area: the next generation of the HH:MM:SS clock that drives hours, minutes and seconds onto the user I/O pads. It adds a configurable prescaler, run/halt control, synchronous time load, 12/24-hour display mode and an hours:minutes alarm with a sticky flag and acknowledge. It sits behind the pad mux and exposes the same 6-bit-per-field output layout as the current clock block.

## Interface
Parameters:
- TICK_DIV, 40_000_000: clock cycles per second, ≥2. Benches use small values, e.g. 4.
- TICK_W, $clog2(TICK_DIV): prescaler width, derived, never overridden.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- run_i  in  1  1 = count; 0 = prescaler and time hold.
- mode12_i  in  1  1 = 12-hour display, 0 = 24-hour.
- load_i  in  1  single-cycle strobe; loads the set_* inputs.
- set_hours_i  in  5  24-hour value 0–23.
- set_minutes_i  in  6  0–59.
- set_seconds_i  in  6  0–59.
- alarm_en_i  in  1  alarm compare enable.
- alarm_hours_i  in  5  24-hour value 0–23.
- alarm_minutes_i  in  6  0–59.
- alarm_ack_i  in  1  clears alarm_o.
- hours_o  out  6  displayed hours.
- minutes_o  out  6  0–59.
- seconds_o  out  6  0–59.
- pm_o  out  1  1 when internal hour ≥12, valid in both modes.
- tick_o  out  1  one-cycle pulse per second increment.
- alarm_o  out  1  sticky alarm flag.

## Operation
- State: prescaler `pre` (TICK_W), hour register `h24` (0–23), minute register `min`, second register `sec`.
- Tick: `tick = run_i && pre == TICK_DIV-1`. On tick, `pre` goes to 0; otherwise, if run_i is 1, `pre` increments.
- Cascade on tick: `sec` increments. At 59 it wraps to 0 and carries to `min`. `min` wraps at 59 and carries to `h24`. `h24` wraps from 23 to 0. At 23:59:59 a tick gives 00:00:00.
- Load:
  - load_i writes `h24`/`min`/`sec` from set_* and clears `pre` to 0.
  - load_i has priority over a same-cycle tick; that tick is discarded and tick_o stays 0.
  - Out-of-range set values (hours >23, min/sec >59) load as 0 for that field only.
  - Load works regardless of run_i.
- Display:
  - minutes_o and seconds_o are `min` and `sec`, zero-extended.
  - With mode12_i=0, hours_o = `h24`.
  - With mode12_i=1, hours_o maps `h24` 0→12, 1–11→same, 12→12, 13–23→`h24`−12.
  - pm_o = (`h24` ≥ 12).
  - These outputs are combinational from the state registers and mode12_i.
- Alarm set: alarm_o sets when a tick produces `h24`==alarm_hours_i, `min`==alarm_minutes_i and `sec`==0, with alarm_en_i=1.
  - A load landing on the alarm time does not fire.
  - Out-of-range alarm values never match.
- Alarm clear: alarm_ack_i clears alarm_o. If a set and an ack occur in the same cycle, the set wins and alarm_o stays 1.
- alarm_en_i=0 blocks new sets but does not clear an existing flag.

## Timing
- Reset values:
  - `pre`, `h24`, `min`, `sec` = 0; tick_o = 0; alarm_o = 0.
  - Hence hours_o = 0 in 24-hour mode or 12 in 12-hour mode; minutes_o = seconds_o = 0; pm_o = 0.
- Reset has priority over load, tick and ack. A reset asserted mid-second discards the partial prescaler count.
- Counter update: on the clock edge where `tick` is true, the new `sec`/`min`/`h24` appear after that edge. tick_o is registered and is high in the same cycle the new value is first visible.
- Seconds period: with run_i held at 1, seconds advance exactly every TICK_DIV cycles.
- After load_i, the first tick comes TICK_DIV cycles later.
- Halt: with run_i=0, `pre` freezes and resumes from the frozen value. A partial second is not lost.
- Alarm latency: alarm_o rises in the same cycle as tick_o for the matching second. An ack clears alarm_o on the next edge.
- mode12_i affects hours_o and pm_o combinationally, with zero cycles of latency.

## Structure
- Shared package `rtc_pkg`:
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths HOUR_W=5, MIN_W=6, SEC_W=6, OUT_W=6.
  - 12-hour conversion function `to_12h`.
- Sub-module `rtc_mod_counter`:
  - Parameters MAX and W.
  - Inputs: en, load, load_val. Outputs: value, carry.
  - carry = en && value==MAX.
  - Instantiated three times for seconds, minutes and hours.
- Top level holds the prescaler, load range checks, display mapping and alarm flag.

## Test plan
All tests use TICK_DIV=4.
- Free-run from reset: seconds_o steps 0→1→…→8 with one step every 4 cycles, and tick_o pulses once per step.
- Load 23:59:58 then run: after 2 ticks the time reads 00:00:00 and pm_o goes 1→0.
- mode12_i=1 with loads of h24=0, 12, 13, 23: hours_o reads 12, 12, 1, 11 and pm_o reads 0, 1, 1, 1.
- Alarm 07:30, alarm_en_i=1, load 07:29:58:
  - After 2 ticks, alarm_o=1 together with tick_o.
  - Ack alone clears it.
  - Ack in the same cycle as a new match leaves alarm_o at 1.
- run_i=0 after 2 cycles into a second, held 10 cycles, then run_i=1: the next tick comes after 2 more cycles.
- Edge cases:
  - load_i coincident with a tick: the loaded value wins and tick_o=0.
  - set_minutes_i=60 loads as 0.
  - wb_rst_i mid-count returns all outputs to their reset values on the next cycle.
